// File: rtl/memory_pipelined_if.sv
// Request/response bundle for memory_pipelined: requests flow master->slave,
// read data and status flow slave->master.
interface memory_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int NUM_LANES  = DATA_WIDTH / 8;

  logic                  write_En;
  logic                  read_En;
  logic [NUM_LANES-1:0]  Byte_En;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Data_in;
  logic                  Clear_in;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  Valid_out;
  logic                  Err_out;
  logic                  Ready_out;

  modport master (
    output write_En, read_En, Byte_En, Address, Data_in, Clear_in,
    input  Data_out, Valid_out, Err_out, Ready_out
  );

  modport slave (
    input  write_En, read_En, Byte_En, Address, Data_in, Clear_in,
    output Data_out, Valid_out, Err_out, Ready_out
  );
endinterface

// File: rtl/memory_pipelined.sv
// Single-port byte-maskable data memory with a fixed-depth read pipeline and a
// self-clearing sequencer that zeroes every word after reset or on request.
module memory_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 64,
  parameter int READ_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  memory_pipelined_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int NUM_LANES  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_ready, w_accept, w_in_range, w_rd_acc, w_wr_ok, w_err;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic [READ_LATENCY-1:0] r_pv, r_pe;
  logic [DATA_WIDTH-1:0]   r_pd [READ_LATENCY];

  assign w_ready    = (r_state == S_IDLE);
  assign w_accept   = w_ready & (bus.write_En | bus.read_En);
  assign w_in_range = ({1'b0, bus.Address} < (ADDR_WIDTH + 1)'(MEM_DEPTH));
  assign w_rd_acc   = w_accept & bus.read_En;
  assign w_wr_ok    = w_accept & bus.write_En & w_in_range;
  assign w_err      = w_accept & ~w_in_range;

  always_comb begin
    w_rd_data = '0;
    if (w_in_range) w_rd_data = r_mem[bus.Address];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_CLEAR: begin
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.Clear_in) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Storage has no reset; the clear sequence defines every word before use.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.Byte_En[i]) r_mem[bus.Address][8*i +: 8] <= bus.Data_in[8*i +: 8];
      end
    end
  end

  // Data stages load only behind a valid so Data_out holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      r_pe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_pv[0] <= w_rd_acc;
      r_pe[0] <= w_err;
      if (w_rd_acc) r_pd[0] <= w_rd_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign bus.Ready_out = w_ready;
  assign bus.Valid_out = r_pv[READ_LATENCY-1];
  assign bus.Err_out   = r_pe[READ_LATENCY-1];
  assign bus.Data_out  = r_pd[READ_LATENCY-1];
endmodule

// File: tb/tb_memory_pipelined.sv
// Bench for memory_pipelined (48 words, read latency 3): directed and random
// traffic checked every cycle against a word-array model with a timed result schedule.
module tb_memory_pipelined;
  localparam int DW    = 32;
  localparam int DEPTH = 48;
  localparam int LAT   = 3;
  localparam int AW    = $clog2(DEPTH);
  localparam int NL    = DW / 8;
  localparam int NE    = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  memory_pipelined_if #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) bus ();

  memory_pipelined #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;
  int clr_left = DEPTH;
  logic [DW-1:0] model_mem [64];
  bit            exp_v   [NE];
  bit            exp_e   [NE];
  logic [DW-1:0] exp_dat [NE];
  logic [DW-1:0] exp_out = '0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, edge_n);
  endtask

  task automatic zero_model();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
  endtask

  // Apply the upcoming edge to the model, advance one clock, then compare.
  task automatic step();
    int   slot;
    logic oob;
    if (rst) begin
      clr_left = DEPTH;
      zero_model();
      for (int i = edge_n + 1; i <= edge_n + LAT + 1; i++) begin
        exp_v[i] = 1'b0;
        exp_e[i] = 1'b0;
      end
    end else if (clr_left == 0) begin
      if (bus.write_En || bus.read_En) begin
        slot = edge_n + LAT;
        oob  = (int'(bus.Address) >= DEPTH);
        exp_v[slot]   = bus.read_En;
        exp_e[slot]   = oob;
        exp_dat[slot] = oob ? '0 : model_mem[bus.Address];
        if (bus.write_En && !oob) begin
          for (int l = 0; l < NL; l++)
            if (bus.Byte_En[l]) model_mem[bus.Address][8*l +: 8] = bus.Data_in[8*l +: 8];
        end
      end
      if (bus.Clear_in) begin
        zero_model();
        clr_left = DEPTH;
      end
    end else begin
      clr_left--;
    end
    @(posedge clk);
    edge_n++;
    #1;
    if (rst) exp_out = '0;
    else if (exp_v[edge_n]) exp_out = exp_dat[edge_n];
    check("ready", DW'(bus.Ready_out), DW'(clr_left == 0 && !rst));
    check("valid", DW'(bus.Valid_out), DW'(exp_v[edge_n] && !rst));
    check("err",   DW'(bus.Err_out),   DW'(exp_e[edge_n] && !rst));
    check("data",  bus.Data_out, exp_out);
  endtask

  task automatic drive(input bit we, input bit re, input logic [NL-1:0] be,
                       input int addr, input logic [DW-1:0] d, input bit clr);
    bus.write_En = we;
    bus.read_En  = re;
    bus.Byte_En  = be;
    bus.Address  = AW'(addr);
    bus.Data_in  = d;
    bus.Clear_in = clr;
  endtask

  task automatic idle(input int n);
    drive(0, 0, '0, 0, '0, 0);
    repeat (n) step();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 1, '0, a, '0, 0);
      step();
    end
    idle(LAT + 1);
  endtask

  initial begin
    drive(0, 0, '0, 0, '0, 0);
    zero_model();
    #2 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    idle(DEPTH + 3);
    read_all();

    // byte-lane merge
    drive(1, 0, 4'b1111, 5, 32'hDEADBEEF, 0); step();
    drive(1, 0, 4'b0101, 5, 32'h11223344, 0); step();
    drive(0, 1, '0, 5, '0, 0); step();
    idle(LAT);
    check("lane_merge", bus.Data_out, 32'hDE22BE44);

    // same-cycle write and read returns old data
    drive(1, 1, 4'b1111, 3, 32'hA5A5A5A5, 0); step();
    idle(LAT - 1);
    check("rw_old", bus.Data_out, 32'h0);
    drive(0, 1, '0, 3, '0, 0); step();
    idle(LAT - 1);
    check("rw_new", bus.Data_out, 32'hA5A5A5A5);

    // out-of-range read and write
    drive(0, 1, '0, 50, '0, 0); step();
    idle(LAT - 1);
    check("oob_rd_err",   DW'(bus.Err_out), DW'(1));
    check("oob_rd_valid", DW'(bus.Valid_out), DW'(1));
    check("oob_rd_data",  bus.Data_out, 32'h0);
    drive(1, 0, 4'b1111, 50, 32'hFFFFFFFF, 0); step();
    idle(LAT - 1);
    check("oob_wr_err",   DW'(bus.Err_out), DW'(1));
    check("oob_wr_valid", DW'(bus.Valid_out), DW'(0));
    idle(2);
    read_all();

    // random traffic, occasional clear requests
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NL'($urandom),
            $urandom_range(0, 63), $urandom, ($urandom_range(0, 39) == 0));
      step();
    end
    idle(DEPTH + LAT);
    read_all();

    // reset discards reads in flight
    drive(0, 1, '0, 3, '0, 0); step();
    drive(0, 1, '0, 5, '0, 0); step();
    drive(0, 0, '0, 0, '0, 0);
    rst = 1'b1;
    repeat (LAT + 1) step();
    rst = 1'b0;
    idle(DEPTH + 2);

    // fill, clear with a same-cycle read, reset halfway through the clear
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, 4'b1111, a, $urandom, 0);
      step();
    end
    drive(0, 1, '0, 7, '0, 1); step();
    idle(DEPTH / 2);
    drive(1, 1, 4'b1111, 9, 32'h12345678, 0); step();
    drive(0, 0, '0, 0, '0, 0);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    idle(DEPTH + 2);
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
